h14tx_period_scheduler: RTL and testbench
=========================================

Name: h14tx_period_scheduler

Overview:
Sequences the HDMI 1.4 TX link. It takes raw DE/HSYNC/VSYNC from the video timing generator and produces the per-cycle period_t, channel CTL codes and delayed syncs that drive all three h14tx encoding channels. It inserts video preambles and guards ahead of DE, and schedules at most one data island per line in horizontal blanking. It hands packets out to the packet serializer through an ack/phase interface.

Parameters:
HBlank, 370, horizontal blanking length in pixel clocks (720p60 default); must be >= 62.
MaxPkts, 18, upper bound on packets per island (HDMI limit).

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
de_i  input  1  data enable from timing generator
hsync_i  input  1  hsync, native polarity
vsync_i  input  1  vsync, native polarity
pkt_valid  input  1  serializer holds a packet ready to send
period  output  period_t  period for encoding tops, all channels
ctl0  output  ctl_t  channel 0 CTL = {vsync,hsync} delayed
ctl1  output  ctl_t  channel 1 CTL bits {CTL1,CTL0}
ctl2  output  ctl_t  channel 2 CTL bits {CTL3,CTL2}
hsync_o  output  1  hsync aligned with period (for TERC4 ch0 bit0)
vsync_o  output  1  vsync aligned with period (for TERC4 ch0 bit1)
pkt_ack  output  1  one-cycle pulse on first active cycle of each packet; serializer pops
pkt_phase  output  5  cycle index 0..31 within current packet, 0 outside islands
island_first  output  1  high on first DataIslandActive cycle of an island only
err  output  1  sticky; island aborted by early DE; cleared only by reset

Behaviour:
- Reset (async, rst_n low): period=Control, ctl0/1/2=0, hsync_o=vsync_o=0, pkt_ack=0, pkt_phase=0, island_first=0, err=0, delay line cleared (DE=0), FSM=Ctl, line flags cleared.
- Latency: de_i/hsync_i/vsync_i at cycle k govern outputs at k+11 (10-stage lookahead line plus output register). The video pixel path must be delayed 11 cycles externally.
- The lookahead window exposes DE for the next 10 output cycles. Define d = DE at the output position, and r = the distance (1..10) to the next DE rise in the window.
- Video rules (highest priority, every cycle):
  - When d=1: VideoActive.
  - When r<=2: VideoGuard.
  - When 3<=r<=10: VideoPreamble, with ctl1=2'b01 and ctl2=2'b00.
  - If blanking is shorter than 10, the preamble is truncated from its front; the guard is always kept whole if blanking >= 2.
- Control: ctl1/ctl2=0 except during preambles. ctl0 always carries the delayed syncs.
- blank_cnt: counts cycles since the d falling edge, saturating at HBlank; reset to 0 while d=1.
- Island grant:
  - Evaluated at blank_cnt==3, when the island_done flag for the line is clear and pkt_valid=1.
  - Npkt_max = min(MaxPkts, (HBlank-30)/32), a constant (10 at default). If Npkt_max=0, islands are never granted.
- Island sequence:
  - DataIslandPreamble for 8 cycles (ctl1=2'b01, ctl2=2'b01).
  - DataIslandGuard for 2 cycles.
  - DataIslandActive in 32-cycle packet slots.
  - DataIslandGuard for 2 cycles.
  - Back to Control; island_done is set.
- FSM states: Ctl, IslPre, IslLead, IslAct, IslTrail, plus video states Vpre, Vgrd, Vact derived from the lookahead. Counters: preamble/guard count 0..7, pkt_phase 0..31, packet count 0..MaxPkts.
- Packet flow:
  - pkt_ack fires when pkt_phase==0 in IslAct.
  - At pkt_phase==31, continue with another slot if pkt_valid=1 and count < Npkt_max; otherwise go to IslTrail.
  - pkt_valid is ignored at all other times.
- Abort: if any video rule triggers while in IslPre, IslLead, IslAct or IslTrail:
  - Video output wins immediately.
  - The island is terminated; no further pkt_ack.
  - err is set and island_done is set.
- island_done clears on the d rising edge. Vertical-blank lines with no DE rise behave as long blanks: one island per HBlank-length window, re-armed when blank_cnt saturates.
- Reset mid-island: outputs go to reset values at once. The partial packet is discarded and the serializer must flush on rst_n.

Decomposition:
- Package h14tx_pkg gains:
  - constants PreambleLen=8, GuardLen=2, PacketLen=32, LookAhead=10, LeadCtl=4;
  - CTL preamble codes CtlVideoPre and CtlIslandPre;
  - the scheduler state enum sched_state_t.
- One sub-module: h14tx_timing_delay, a parameterised-depth shift register for {de,hsync,vsync} that exposes all taps for lookahead.

Test Plan:
1. HBlank=370, pkt_valid pulsed for one packet, d falls at t=0 -> Control 0-3, DIPreamble 4-11, DIGuard 12-13, DIActive 14-45 (pkt_ack and island_first at 14), DIGuard 46-47, Control 48-359, VideoPreamble 360-367, VideoGuard 368-369, VideoActive 370.
2. pkt_valid held high -> 10 packets, pkt_ack at 14,46,...,302; DIActive 14-333; trailing guard 334-335; err=0.
3. pkt_valid low at blank_cnt==3 -> no island in the line, only Control then video preamble/guard; pkt_ack never pulses.
4. Blank of 6 cycles between DE runs -> VideoPreamble 4 cycles, VideoGuard 2 cycles, no island.
5. DE rises early at blank_cnt=40 during an island -> VideoPreamble from blank_cnt 30, island cut, err=1 and stays 1 until rst_n.
6. rst_n asserted at pkt_phase=17 -> next edge: period=Control, pkt_phase=0, err=0. After release, 11 cycles of Control before any input-driven change.

Source files
------------

// File: rtl/h14tx_pkg.sv
//------------------------------------------------------------------------------
// Module      : h14tx_pkg
// Description : Shared types and constants for the HDMI 1.4 TX link sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package h14tx_pkg;

    typedef enum logic [2:0] {
        Control            = 3'd0,
        VideoPreamble      = 3'd1,
        VideoGuard         = 3'd2,
        VideoActive        = 3'd3,
        DataIslandPreamble = 3'd4,
        DataIslandGuard    = 3'd5,
        DataIslandActive   = 3'd6
    } period_t;

    typedef logic [1:0] ctl_t;

    localparam int c_PreambleLen = 8;
    localparam int c_GuardLen    = 2;
    localparam int c_PacketLen   = 32;
    localparam int c_LookAhead   = 10;
    localparam int c_LeadCtl     = 4;

    // {CTL3,CTL2,CTL1,CTL0}
    localparam logic [3:0] c_CtlVideoPre  = 4'b0001;
    localparam logic [3:0] c_CtlIslandPre = 4'b0101;

    typedef enum logic [2:0] {
        Ctl      = 3'd0,
        IslPre   = 3'd1,
        IslLead  = 3'd2,
        IslAct   = 3'd3,
        IslTrail = 3'd4,
        Vpre     = 3'd5,
        Vgrd     = 3'd6,
        Vact     = 3'd7
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/h14tx_timing_delay.sv
//------------------------------------------------------------------------------
// Module      : h14tx_timing_delay
// Description : Shift register for timing signals exposing every tap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module h14tx_timing_delay #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din_i,
    output logic [DEPTH*WIDTH-1:0] taps_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Tap g holds the input delayed by g+1 cycles.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_tap
            assign taps_o[g*WIDTH +: WIDTH] = stage_q[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/h14tx_period_scheduler.sv
//------------------------------------------------------------------------------
// Module      : h14tx_period_scheduler
// Description : Per-cycle HDMI period/CTL sequencer with data island scheduling.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module h14tx_period_scheduler
    import h14tx_pkg::*;
#(
    parameter int HBLANK   = 370,
    parameter int MAX_PKTS = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        pkt_valid,
    output period_t     period,
    output ctl_t        ctl0,
    output ctl_t        ctl1,
    output ctl_t        ctl2,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        pkt_ack,
    output logic [4:0]  pkt_phase,
    output logic        island_first,
    output logic        err
);

    localparam int c_NpktRaw = (HBLANK - 30) / 32;
    localparam int c_Npkt    = (c_NpktRaw < MAX_PKTS) ? c_NpktRaw : MAX_PKTS;
    localparam int c_CntW    = $clog2(HBLANK + 1);
    localparam int c_PcntW   = $clog2(MAX_PKTS + 1);

    logic [c_LookAhead*3-1:0] w_taps;
    logic [c_LookAhead:0]     w_de_at;
    logic                     w_unused_taps;
    sched_state_t             w_vstate;

    h14tx_timing_delay #(.DEPTH(c_LookAhead), .WIDTH(3)) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  ({vsync_i, hsync_i, de_i}),
        .taps_o (w_taps)
    );

    // w_de_at[j] is DE j cycles after the output position being computed.
    generate
        for (genvar g = 0; g < c_LookAhead; g++) begin : g_win
            assign w_de_at[g] = w_taps[(c_LookAhead-1-g)*3];
        end
    endgenerate
    assign w_de_at[c_LookAhead] = de_i;
    assign w_unused_taps        = ^w_taps;

    always_comb begin
        w_vstate = Ctl;
        if (w_de_at[0])                      w_vstate = Vact;
        else if (w_de_at[1] || w_de_at[2])   w_vstate = Vgrd;
        else if (|w_de_at[c_LookAhead:3])    w_vstate = Vpre;
    end

    sched_state_t        state_q, state_d;
    logic [2:0]          gcnt_q, gcnt_d;
    logic [4:0]          phase_q, phase_d;
    logic [c_PcntW-1:0]  pcnt_q, pcnt_d;
    logic [c_CntW-1:0]   blank_cnt_q, blank_cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    period_t             period_q, w_period;
    logic [3:0]          ctl_pre_q, w_ctl_pre;
    logic [1:0]          sync_q;
    logic                ack_q, w_ack, first_q, w_first;
    logic [4:0]          phase_out_q, w_phase;
    logic                w_grant;

    assign w_grant = (blank_cnt_q == c_CntW'(c_LeadCtl - 1)) && !done_q && pkt_valid
                     && (c_Npkt > 0);

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        phase_d   = phase_q;
        pcnt_d    = pcnt_q;
        done_d    = done_q;
        err_d     = err_q;
        w_period  = Control;
        w_ctl_pre = '0;
        w_ack     = 1'b0;
        w_first   = 1'b0;
        w_phase   = '0;
        if (w_vstate != Ctl) begin
            // Video always wins; a pending island is cut short.
            state_d = Ctl;
            case (w_vstate)
                Vact:    w_period = VideoActive;
                Vgrd:    w_period = VideoGuard;
                default: begin
                    w_period  = VideoPreamble;
                    w_ctl_pre = c_CtlVideoPre;
                end
            endcase
            if (state_q != Ctl) begin
                err_d  = 1'b1;
                done_d = 1'b1;
            end
        end else begin
            case (state_q)
                IslPre: begin
                    w_period  = DataIslandPreamble;
                    w_ctl_pre = c_CtlIslandPre;
                    if (gcnt_q == 3'(c_PreambleLen - 1)) begin
                        state_d = IslLead;
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q + 3'd1;
                    end
                end
                IslLead: begin
                    w_period = DataIslandGuard;
                    if (gcnt_q == 3'(c_GuardLen - 1)) begin
                        state_d = IslAct;
                        phase_d = '0;
                        pcnt_d  = c_PcntW'(1);
                    end else begin
                        gcnt_d = gcnt_q + 3'd1;
                    end
                end
                IslAct: begin
                    w_period = DataIslandActive;
                    w_phase  = phase_q;
                    w_ack    = (phase_q == '0);
                    w_first  = (phase_q == '0) && (pcnt_q == c_PcntW'(1));
                    if (phase_q == 5'(c_PacketLen - 1)) begin
                        if (pkt_valid && (pcnt_q < c_PcntW'(c_Npkt))) begin
                            phase_d = '0;
                            pcnt_d  = pcnt_q + c_PcntW'(1);
                        end else begin
                            state_d = IslTrail;
                            gcnt_d  = '0;
                        end
                    end else begin
                        phase_d = phase_q + 5'd1;
                    end
                end
                IslTrail: begin
                    w_period = DataIslandGuard;
                    if (gcnt_q == 3'(c_GuardLen - 1)) begin
                        state_d = Ctl;
                        done_d  = 1'b1;
                    end else begin
                        gcnt_d = gcnt_q + 3'd1;
                    end
                end
                default: begin
                    if (w_grant) begin
                        state_d = IslPre;
                        gcnt_d  = '0;
                    end
                end
            endcase
        end
        // Re-arm on a new line, or after a full blanking window with no DE.
        if (w_de_at[0] || (blank_cnt_q == c_CntW'(HBLANK))) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        blank_cnt_d = blank_cnt_q + c_CntW'(1);
        if (w_de_at[0] || (blank_cnt_q == c_CntW'(HBLANK))) begin
            blank_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= Ctl;
            gcnt_q      <= '0;
            phase_q     <= '0;
            pcnt_q      <= '0;
            blank_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            period_q    <= Control;
            ctl_pre_q   <= '0;
            sync_q      <= '0;
            ack_q       <= 1'b0;
            first_q     <= 1'b0;
            phase_out_q <= '0;
        end else begin
            state_q     <= state_d;
            gcnt_q      <= gcnt_d;
            phase_q     <= phase_d;
            pcnt_q      <= pcnt_d;
            blank_cnt_q <= blank_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            period_q    <= w_period;
            ctl_pre_q   <= w_ctl_pre;
            sync_q      <= {w_taps[(c_LookAhead-1)*3+2], w_taps[(c_LookAhead-1)*3+1]};
            ack_q       <= w_ack;
            first_q     <= w_first;
            phase_out_q <= w_phase;
        end
    end

    assign period       = period_q;
    assign ctl0         = sync_q;
    assign ctl1         = ctl_pre_q[1:0];
    assign ctl2         = ctl_pre_q[3:2];
    assign hsync_o      = sync_q[0];
    assign vsync_o      = sync_q[1];
    assign pkt_ack      = ack_q;
    assign pkt_phase    = phase_out_q;
    assign island_first = first_q;
    assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_h14tx_period_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_h14tx_period_scheduler
// Description : Self-checking bench with directed line table and random lines.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_h14tx_period_scheduler;
    import h14tx_pkg::*;

    localparam int HBLANK   = 370;
    localparam int MAX_PKTS = 18;
    localparam int NPKT     = ((HBLANK - 30) / 32 < MAX_PKTS) ? (HBLANK - 30) / 32 : MAX_PKTS;
    localparam int MAXC     = 65536;

    logic clk = 1'b0, rst_n = 1'b0;
    logic de_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0, pkt_valid = 1'b0;
    period_t period;
    ctl_t ctl0, ctl1, ctl2;
    logic hsync_o, vsync_o, pkt_ack, island_first, err;
    logic [4:0] pkt_phase;

    h14tx_period_scheduler #(.HBLANK(HBLANK), .MAX_PKTS(MAX_PKTS)) dut (
        .clk(clk), .rst_n(rst_n), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .pkt_valid(pkt_valid), .period(period), .ctl0(ctl0), .ctl1(ctl1), .ctl2(ctl2),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .pkt_ack(pkt_ack), .pkt_phase(pkt_phase),
        .island_first(island_first), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit de_h [MAXC];
    bit hs_h [MAXC];
    bit vs_h [MAXC];
    bit pv_h [MAXC];

    // Reference model state: blank run length, line flag, sticky error, island plan.
    int m_cnt;
    bit m_done, m_err, m_isl;
    int m_start, m_npk;

    function automatic bit h_de(int i); return (i < 0) ? 1'b0 : de_h[i]; endfunction
    function automatic bit h_hs(int i); return (i < 0) ? 1'b0 : hs_h[i]; endfunction
    function automatic bit h_vs(int i); return (i < 0) ? 1'b0 : vs_h[i]; endfunction
    function automatic bit h_pv(int i); return (i < 0) ? 1'b0 : pv_h[i]; endfunction

    function automatic logic [18:0] observed();
        return {period, ctl0, ctl1, ctl2, hsync_o, vsync_o, pkt_ack, pkt_phase, island_first, err};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_done = 0; m_err = 0; m_isl = 0; m_start = 0; m_npk = 0;
    endtask

    // Expected outputs for output cycle m, planned from the island's start offset.
    task automatic model_eval(input int m, output logic [18:0] e);
        bit d, ack, first;
        int r, off, a, ph;
        period_t p;
        logic [1:0] c1, c2;
        d = h_de(m - 11);
        r = 0;
        if (!d) for (int j = 1; j <= 10; j++) if (r == 0 && h_de(m - 11 + j)) r = j;
        p = Control; c1 = 2'b00; c2 = 2'b00; ack = 0; first = 0; ph = 0;
        if (d || r != 0) begin
            p = d ? VideoActive : (r <= 2 ? VideoGuard : VideoPreamble);
            if (p == VideoPreamble) c1 = 2'b01;
            if (m_isl) begin m_err = 1; m_done = 1; m_isl = 0; end
        end else if (m_isl) begin
            off = m - m_start;
            if (off < 8) begin
                p = DataIslandPreamble; c1 = 2'b01; c2 = 2'b01;
            end else if (off < 10) begin
                p = DataIslandGuard;
            end else begin
                a = off - 10;
                if (a < 32 * m_npk) begin
                    p = DataIslandActive;
                    ph = a % 32;
                    ack = (ph == 0);
                    first = (a == 0);
                    if (ph == 31 && a / 32 == m_npk - 1 && h_pv(m - 1) && m_npk < NPKT) m_npk++;
                end else begin
                    p = DataIslandGuard;
                    if (a - 32 * m_npk == 1) begin m_isl = 0; m_done = 1; end
                end
            end
        end else if (m_cnt == 3 && !m_done && h_pv(m - 1) && NPKT > 0) begin
            m_isl = 1; m_start = m + 1; m_npk = 1;
        end
        if (d || m_cnt == HBLANK) m_done = 0;
        m_cnt = (d || m_cnt == HBLANK) ? 0 : m_cnt + 1;
        e = {p, h_vs(m - 11), h_hs(m - 11), c1, c2, h_hs(m - 11), h_vs(m - 11),
             ack, 5'(ph), first, m_err};
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input bit de, input bit pv);
        logic [18:0] e, g;
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget got=%0d want<%0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        de_i = de; pkt_valid = pv;
        hsync_i = 1'($urandom); vsync_i = 1'($urandom);
        de_h[cyc] = de; pv_h[cyc] = pv; hs_h[cyc] = hsync_i; vs_h[cyc] = vsync_i;
        @(posedge clk); #1;
        cyc++;
        model_eval(cyc, e);
        g = observed();
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL out@%0d got=%h want=%h", cyc, g, e);
        end
    endtask

    // pvmode: 0 idle, 1 one packet (drop after ack), 2 held, 3 random.
    task automatic run_seg(input int blank, input int act, input int pvmode,
                           output int n_dipre, output int n_off, output int n_acks,
                           output int n_vpre, output int n_vgrd, output int n_diact);
        bit started, ack_seen, pv;
        int pos;
        started = 0; ack_seen = 0; pos = 0;
        n_dipre = 0; n_off = -1; n_acks = 0; n_vpre = 0; n_vgrd = 0; n_diact = 0;
        for (int i = 0; i < blank + act; i++) begin
            case (pvmode)
                1:       pv = !ack_seen;
                2:       pv = 1'b1;
                3:       pv = 1'($urandom);
                default: pv = 1'b0;
            endcase
            step(i >= blank, pv);
            if (pkt_ack) ack_seen = 1;
            if (!started && period != VideoActive) started = 1;
            if (started) begin
                if (period == DataIslandPreamble) begin
                    n_dipre++;
                    if (n_off < 0) n_off = pos;
                end
                if (period == VideoPreamble)    n_vpre++;
                if (period == VideoGuard)       n_vgrd++;
                if (period == DataIslandActive) n_diact++;
                if (pkt_ack)                    n_acks++;
                pos++;
            end
        end
    endtask

    typedef struct {
        int blank; int pvmode;
        int e_dipre; int e_off; int e_acks; int e_vpre; int e_vgrd; int e_diact; bit e_err;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int nd, no, na, nvp, nvg, nda, guard;
        logic [18:0] zero_exp;

        tbl[0] = '{370, 1, 8,  4,  1, 8, 2,  32, 1'b0};
        tbl[1] = '{370, 2, 8,  4, 10, 8, 2, 320, 1'b0};
        tbl[2] = '{370, 0, 0, -1,  0, 8, 2,   0, 1'b0};
        tbl[3] = '{  6, 2, 0, -1,  0, 4, 2,   0, 1'b0};
        tbl[4] = '{ 40, 2, 8,  4,  1, 8, 2,  16, 1'b1};
        tbl[5] = '{  2, 0, 0, -1,  0, 0, 2,   0, 1'b1};
        zero_exp = {Control, 16'h0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(observed()), int'(zero_exp));
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            run_seg(tbl[t].blank, 16, tbl[t].pvmode, nd, no, na, nvp, nvg, nda);
            chk($sformatf("v%0d_dipre", t), nd, tbl[t].e_dipre);
            chk($sformatf("v%0d_off", t), no, tbl[t].e_off);
            chk($sformatf("v%0d_acks", t), na, tbl[t].e_acks);
            chk($sformatf("v%0d_vpre", t), nvp, tbl[t].e_vpre);
            chk($sformatf("v%0d_vgrd", t), nvg, tbl[t].e_vgrd);
            chk($sformatf("v%0d_diact", t), nda, tbl[t].e_diact);
            chk($sformatf("v%0d_err", t), int'(err), int'(tbl[t].e_err));
        end

        for (int s = 0; s < 30; s++) begin
            run_seg($urandom_range(1, HBLANK), $urandom_range(1, 40), $urandom_range(0, 3),
                    nd, no, na, nvp, nvg, nda);
        end

        // Reset in the middle of a packet.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        guard = 0;
        while (!(period == DataIslandActive && pkt_phase == 5'd17) && guard < 200) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("reach_phase17", guard < 200 ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(observed()), int'(zero_exp));
        @(posedge clk); #1;
        chk("reset_edge_outputs", int'(observed()), int'(zero_exp));
        rst_n = 1'b1;
        cyc = 0;
        model_reset();
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0);
            chk($sformatf("post_reset_ctl%0d", i), int'(period), int'(Control));
        end
        for (int s = 0; s < 20; s++) begin
            run_seg($urandom_range(1, HBLANK), $urandom_range(1, 40), $urandom_range(0, 3),
                    nd, no, na, nvp, nvg, nda);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
